// File: rtl/toggle_debounce_if.sv
// toggle_debounce_if: button-request / T-pulse bundle for toggle_debounce.
// Ports: btn_in, en (to conditioner); T, stable, busy, press_count (from it).
`timescale 1ns/1ps
interface toggle_debounce_if #(
  parameter int PCNT_W = 8
);
  logic              btn_in;
  logic              en;
  logic              T;
  logic              stable;
  logic              busy;
  logic [PCNT_W-1:0] press_count;

  modport master (
    output btn_in,
    output en,
    input  T,
    input  stable,
    input  busy,
    input  press_count
  );

  modport slave (
    input  btn_in,
    input  en,
    output T,
    output stable,
    output busy,
    output press_count
  );
endinterface

// File: rtl/toggle_debounce.sv
// toggle_debounce: sync + debounce a bouncy button, one T pulse per press.
// Ports: clk, reset (sync, active-high); io.btn_in/en in; io.T/stable/busy/press_count out.
`timescale 1ns/1ps
module toggle_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int PCNT_W          = 8
) (
  input logic              clk,
  input logic              reset,
  toggle_debounce_if.slave io
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              sync1;
  logic              sync2;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              accept;
  logic              t_q;
  logic              stable_q;
  logic              busy_q;
  logic [PCNT_W-1:0] pcnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_d = PRESSED;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // stable/busy are decoded from the next state so they
  // move on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      t_q      <= 1'b0;
      stable_q <= 1'b0;
      busy_q   <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      sync1    <= io.btn_in;
      sync2    <= sync1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_q      <= accept & io.en;
      stable_q <= (state_d == PRESSED) ||
                  (state_d == WAIT_LOW);
      busy_q   <= (state_d == WAIT_HIGH) ||
                  (state_d == WAIT_LOW);
      if (accept) begin
        pcnt_q <= pcnt_q + 1'b1;
      end
    end
  end

  assign io.T           = t_q;
  assign io.stable      = stable_q;
  assign io.busy        = busy_q;
  assign io.press_count = pcnt_q;

endmodule

// File: tb/tb_toggle_debounce.sv
// tb_toggle_debounce: directed checks of toggle_debounce.
// Two instances: DEBOUNCE_CYCLES = 4 (main) and 1 (boundary).
`timescale 1ns/1ps
module tb_toggle_debounce;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic btn   = 1'b0;
  logic en    = 1'b1;

  int n_vec   = 0;
  int n_bad   = 0;
  int pulses4 = 0;
  int p0      = 0;
  logic saw_busy;

  always #5 clk = ~clk;

  toggle_debounce_if #(.PCNT_W(8)) b4 ();
  toggle_debounce_if #(.PCNT_W(8)) b1 ();

  assign b4.btn_in = btn;
  assign b4.en     = en;
  assign b1.btn_in = btn;
  assign b1.en     = en;

  toggle_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .PCNT_W(8)
  ) dut4 (
    .clk(clk),
    .reset(reset),
    .io(b4.slave)
  );

  toggle_debounce #(
    .DEBOUNCE_CYCLES(1),
    .CNT_W(16),
    .PCNT_W(8)
  ) dut1 (
    .clk(clk),
    .reset(reset),
    .io(b1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (b4.T === 1'b1) pulses4++;
  endtask

  task automatic press(input logic e);
    en  = e;
    btn = 1'b1;
    repeat (12) tick();
    btn = 1'b0;
    repeat (12) tick();
    en  = 1'b1;
  endtask

  initial begin
    // 1: reset, then idle
    reset = 1'b1;
    tick();
    tick();
    chk("rst_T", 32'(b4.T), 32'd0);
    chk("rst_stable", 32'(b4.stable), 32'd0);
    chk("rst_busy", 32'(b4.busy), 32'd0);
    chk("rst_cnt", 32'(b4.press_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", {b4.T, b4.stable, b4.busy,
                   b4.press_count}, 32'd0);
    end

    // 2: clean press, both debounce depths
    btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("p4_busy", 32'(b4.busy),
          32'(k >= 3 && k <= 6));
      chk("p4_T", 32'(b4.T), 32'(k == 7));
      chk("p4_stable", 32'(b4.stable), 32'(k >= 7));
      chk("p1_busy", 32'(b1.busy), 32'(k == 3));
      chk("p1_T", 32'(b1.T), 32'(k == 4));
      chk("p1_stable", 32'(b1.stable), 32'(k >= 4));
    end
    chk("p4_cnt", 32'(b4.press_count), 32'd1);
    chk("p1_cnt", 32'(b1.press_count), 32'd1);

    // 4: release bounce, then clean release
    p0       = pulses4;
    saw_busy = 1'b0;
    btn      = 1'b0;
    tick();
    saw_busy |= b4.busy;
    tick();
    saw_busy |= b4.busy;
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      saw_busy |= b4.busy;
      chk("rb_stable", 32'(b4.stable), 32'd1);
    end
    chk("rb_busy_seen", 32'(saw_busy), 32'd1);
    chk("rb_pulses", 32'(pulses4 - p0), 32'd0);
    chk("rb_cnt", 32'(b4.press_count), 32'd1);
    btn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rel_stable", 32'(b4.stable), 32'(k < 7));
      chk("rel_busy", 32'(b4.busy),
          32'(k >= 3 && k <= 6));
    end

    // 3: press bounce: 3 high, 1 low, then held
    repeat (3) tick();
    p0  = pulses4;
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) btn = 1'b0;
      if (k == 4) btn = 1'b1;
      chk("bn_T", 32'(b4.T), 32'(k == 11));
    end
    chk("bn_pulses", 32'(pulses4 - p0), 32'd1);
    chk("bn_cnt", 32'(b4.press_count), 32'd2);
    btn = 1'b0;
    repeat (12) tick();
    chk("bn_rel", 32'(b4.stable), 32'd0);

    // 5: en gating
    p0 = pulses4;
    press(1'b0);
    chk("en0_pulses", 32'(pulses4 - p0), 32'd0);
    chk("en0_cnt", 32'(b4.press_count), 32'd3);
    p0 = pulses4;
    press(1'b1);
    chk("en1_pulses", 32'(pulses4 - p0), 32'd1);
    chk("en1_cnt", 32'(b4.press_count), 32'd4);

    // 6a: press_count wrap
    repeat (251) press(1'b1);
    chk("cnt_255", 32'(b4.press_count), 32'd255);
    press(1'b1);
    chk("cnt_wrap", 32'(b4.press_count), 32'd0);

    // 6b: reset during WAIT_HIGH with button held
    btn = 1'b1;
    repeat (4) tick();
    chk("wh_busy", 32'(b4.busy), 32'd1);
    p0    = pulses4;
    reset = 1'b1;
    tick();
    tick();
    chk("mr_T", 32'(b4.T), 32'd0);
    chk("mr_busy", 32'(b4.busy), 32'd0);
    chk("mr_stable", 32'(b4.stable), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ar_T", 32'(b4.T), 32'(k == 7));
    end
    chk("ar_pulses", 32'(pulses4 - p0), 32'd1);
    chk("ar_cnt", 32'(b4.press_count), 32'd1);

    // holding produces no repeat pulse
    p0 = pulses4;
    repeat (20) tick();
    chk("hold_pulses", 32'(pulses4 - p0), 32'd0);
    btn = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_debounce.md
Name: toggle_debounce

Overview:
- Upstream conditioning stage for the T flip-flop.
- Takes a raw, bouncy, asynchronous push-button/toggle request and synchronises and debounces it.
- Emits exactly one single-cycle T pulse per accepted press, driving the T input of the T flip-flop on the same clk.
- Also exports the debounced level and a wrapping press counter for status/debug.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised-stable cycles required to accept a level change; legal range 1 to 2^CNT_W.
- CNT_W, 16, width of the internal debounce counter.
- PCNT_W, 8, width of press_count.

Ports:
- clk  input  1  rising-edge clock shared with the T flip-flop.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous request; may bounce.
- en  input  1  pulse enable; when 0, T is held 0 but the FSM still tracks the button.
- T  output  1  one-cycle toggle pulse per accepted press; feeds the T flip-flop's T input.
- stable  output  1  debounced button level.
- busy  output  1  high while in WAIT_HIGH or WAIT_LOW.
- press_count  output  PCNT_W  count of accepted presses, wraps.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset is sampled on a clk rising edge and has priority over everything else.
- Reset values:
  - sync1 = sync2 = 0, state = IDLE, cnt = 0.
  - T = 0, stable = 0, busy = 0, press_count = 0.
- Synchroniser: two-flop chain btn_in -> sync1 -> sync2. Only sync2 is used by the FSM.
- FSM, all transitions on clk rising edge:
  - IDLE (stable = 0): if sync2 = 1, go to WAIT_HIGH and set cnt = 0.
  - WAIT_HIGH (stable = 0, busy = 1):
    - if sync2 = 0, return to IDLE (bounce rejected, no pulse);
    - else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED;
    - else cnt = cnt+1.
  - PRESSED (stable = 1): if sync2 = 0, go to WAIT_LOW and set cnt = 0.
  - WAIT_LOW (stable = 1, busy = 1):
    - if sync2 = 1, return to PRESSED (release bounce rejected, no new pulse);
    - else if cnt = DEBOUNCE_CYCLES-1, go to IDLE;
    - else cnt = cnt+1.
- Acceptance (WAIT_HIGH -> PRESSED transition), on that same edge:
  - T <= en. T is registered and high for exactly one cycle, then returns to 0.
  - press_count <= press_count+1 regardless of en; wraps 2^PCNT_W-1 -> 0.
- Latency: btn_in goes high and stays high before clk edge 1.
  - Edge 2: sync2 = 1.
  - Edge 3: enter WAIT_HIGH.
  - Edge 3+DEBOUNCE_CYCLES: enter PRESSED with T = 1.
  - Edge 4+DEBOUNCE_CYCLES: T = 0.
- Release latency is symmetric: stable falls at edge 3+DEBOUNCE_CYCLES after btn_in falls.
- stable and busy are registered and change on the same edge as the state change.
- Holding the button high produces no repeat pulses; only the first accepted press pulses.
- en deasserted at the acceptance edge: no pulse, and no deferred pulse later.
- Reset mid-WAIT_HIGH or while in PRESSED:
  - returns to IDLE, no pulse;
  - if btn_in is still high after reset is released, a full new debounce follows and a pulse is produced.
- DEBOUNCE_CYCLES = 1: WAIT_HIGH lasts one cycle, so T rises at edge 4.
- Downstream contract: at most one T pulse per 2*DEBOUNCE_CYCLES+2 cycles, so Q toggles exactly once per accepted press.

Test Plan:
1. Reset held 2 cycles, then btn_in = 0 for 10 cycles -> T = 0, stable = 0, busy = 0, press_count = 0 throughout.
2. DEBOUNCE_CYCLES = 4, en = 1; btn_in goes 0 -> 1 before edge 1 and is held -> busy = 1 from edge 3; T = 1 only in the cycle after edge 7; stable = 1 from edge 7; press_count = 1.
3. Bounce: btn_in high for 3 cycles, low for 1, then high and held -> no pulse from the first burst; exactly one T pulse, 7 edges after the final rise.
4. Release bounce: from PRESSED, btn_in low for 2 cycles, then high -> stable stays 1, no T pulse, press_count unchanged; a clean release then gives stable = 0 after 3+4 edges.
5. en = 0 during one accepted press, en = 1 during the next -> first press: T stays 0 and press_count goes to 1; second press: T pulses and press_count = 2.
6. press_count = 255 plus one accepted press -> press_count = 0. Separately, reset asserted in WAIT_HIGH with btn_in held high -> no pulse during reset; exactly one pulse 7 edges after reset is released.
